// File: rtl/pipe_if_id_queue.sv
// pipe_if_id_queue: FWFT instruction queue between the fetch and decode stages
//   clk, clr              : clock, synchronous active-high reset
//   in_valid/in_ready     : fetch-side handshake carrying in_pc/in_inst
//   flush                 : redirect, discards every queued entry
//   out_valid/out_ready   : decode-side handshake carrying out_pc/out_inst/out_pc4
//   count                 : occupancy 0..DEPTH
//   flushed               : one-cycle pulse after a flush that discarded work
module pipe_if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc4,
    output logic [AW:0]   count,
    output logic          flushed
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          flushed_q, flushed_d;
    logic          push, pop;
    always_comb begin
        in_ready  = !clr && (cnt_q < FULL);
        out_valid = cnt_q != '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_pc    = out_valid ? mem_pc[rd_q] : '0;
        out_inst  = out_valid ? mem_inst[rd_q] : '0;
        out_pc4   = out_pc + 32'd4;
        count     = cnt_q;
        flushed   = flushed_q;
        rd_d      = flush ? '0 : rd_q + AW'(pop);
        wr_d      = flush ? '0 : wr_q + AW'(push);
        cnt_d     = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        flushed_d = flush && (out_valid || push);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            flushed_q <= flushed_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[wr_q]   <= in_pc;
            mem_inst[wr_q] <= in_inst;
        end
    end
endmodule

// File: doc/pipe_if_id_queue.md
# pipe_if_id_queue

Instruction queue on the consumer side of the fetch stage: accepts `{pc, inst}` pairs from the IF stage and hands them to the ID stage in program order. It decouples fetch from decode with a small FIFO, a valid/ready handshake on both sides, and a branch-flush input. It sits between the fetch stage's `pc`/`newInst` outputs and the decode stage input.

## Interface
- `DEPTH`, default 4: queue entries; a power of two, ≥2.
- `AW`, default 2: pointer width; must equal log2(DEPTH).

Ports (`clk`, `clr` first):
- `clk` in 1: single clock; all state changes on the rising edge.
- `clr` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch stage presents a valid pair.
- `in_ready` out 1: queue can accept this cycle.
- `in_pc` in 32: PC of the fetched instruction.
- `in_inst` in 32: fetched instruction word.
- `flush` in 1: branch/jump redirect; discard all queued entries.
- `out_valid` out 1: head entry available to decode.
- `out_ready` in 1: decode consumes the head this cycle.
- `out_pc` out 32: head PC.
- `out_inst` out 32: head instruction.
- `out_pc4` out 32: head PC + 4.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `flushed` out 1: registered one-cycle pulse after a flush that discarded ≥1 entry or an accepted push.

## Operation
- Storage is a DEPTH-entry array plus read pointer, write pointer and count. Pointers are AW bits and wrap modulo DEPTH.
- **Push:** `in_valid && in_ready` at the edge. Writes `{in_pc, in_inst}` at the write pointer; the write pointer increments.
- **Pop:** `out_valid && out_ready` at the edge. The read pointer increments.
- **Simultaneous push and pop (non-flush):**
  - `count` is unchanged.
  - Legal at any occupancy 1..DEPTH-1.
  - At `count==DEPTH`, `in_ready` is 0, so no push occurs. There is no full-bypass.
- **Flush (`flush==1`):**
  - Pointers and count go to 0 at the edge. Any push or pop that cycle is ignored.
  - `flushed` is 1 the next cycle if the pre-edge count was nonzero or `in_valid && in_ready` was true.
- **Output behaviour:**
  - Outputs are first-word-fall-through: `out_valid = (count != 0)`.
  - `out_pc`/`out_inst` come from the head entry when `out_valid` is 1. Otherwise they are 0, so the instruction output is a NOP.
  - `out_pc4 = out_pc + 32'd4`, modulo 2^32: `32'hFFFF_FFFC` yields `32'h0000_0000`.
- `in_ready = !clr && (count < DEPTH)`. It does not depend on `out_ready` or `flush`.
- Array contents are not reset. Only pointers, count and `flushed` are reset.

## Timing
- **Reset:** with `clr` high at an edge, the following values hold from the next cycle:
  - `count=0`, `out_valid=0`, `out_pc=0`, `out_inst=0`, `out_pc4=4`, `flushed=0`.
  - `in_ready=0` while `clr` is high, and 1 once `clr` is low.
  - `clr` has priority over `flush`, push and pop.
- **Latency:** a push at edge N is visible on `out_*` in the cycle after edge N. When the queue was empty, it can be popped at edge N+1.
- **Throughput:** 1 push and 1 pop per cycle sustained.
- **Full:** `count==DEPTH` gives `in_ready=0`. A pop at that edge re-raises `in_ready` the following cycle.
- **Empty:** `out_valid=0`. `out_ready` is ignored, and the pointers do not move.
- **Producer/consumer rules:**
  - The producer must hold `in_pc`/`in_inst` stable while `in_valid && !in_ready`.
  - `out_*` are stable until a pop, flush or reset.
- **Reset mid-operation:** all entries are lost, with the same result as a flush but without the `flushed` pulse.
- `in_ready`, `out_valid` and `out_*` are combinational from state only. There is no input-to-output combinational path except `in_ready`/`clr`.

## Test plan
- **Reset then fill:**
  - Stimulus: `clr` for 2 cycles, then push pc=`0x0000_0000`,`0x4`,`0x8`,`0xC` (inst=`0x2001_000N`) with `out_ready=0`.
  - Response: `count` 1,2,3,4; `in_ready=0` after the 4th push; `out_pc=0`, `out_pc4=4` throughout.
- **Drain in order:**
  - Stimulus: from full, `out_ready=1` for 4 cycles.
  - Response: `out_pc` sequence `0,4,8,0xC`, insts match; then `out_valid=0`, `out_inst=0`, `count=0`.
- **Streaming with wrap:**
  - Stimulus: `in_valid=out_ready=1` continuously for 10 pushes, pc `0x100..0x124`.
  - Response: `count` stays 1 after the first push, pops appear in order, pointers wrap past DEPTH with no loss.
- **Flush with simultaneous push/pop:**
  - Stimulus: with count=3, assert `flush` together with `in_valid` and `out_ready`.
  - Response: next cycle `count=0`, `out_valid=0`, `flushed=1` for exactly 1 cycle; the pushed pair never appears.
- **Full boundary:**
  - Stimulus: at count=4 drive `in_valid=1` (pc=`0x200`) and `out_ready=1`.
  - Response: that edge pops only, `count=3`; next cycle `in_ready=1` and `0x200` is accepted.
- **Wrap arithmetic and reset mid-stream:**
  - Stimulus: push pc=`0xFFFF_FFFC`, then assert `clr` with count=2.
  - Response: `out_pc4=0x0000_0000` before reset; after the `clr` edge `count=0`, `flushed=0`, outputs 0.
